// File: rtl/req_order_arbiter.sv
// First-come-first-served arbiter granting a shared single-entry sink to
// NUM_PORTS level requesters, with an order queue, empty-queue bypass and flush.
module req_order_arbiter #(
  parameter int NUM_PORTS = 4,
  parameter int DEPTH     = 4,
  parameter bit TIE_RR    = 1'b0,
  parameter int PORT_W    = $clog2(NUM_PORTS)
) (
  input  logic                         clk,
  input  logic                         rst_b,
  input  logic [NUM_PORTS-1:0]         req,
  input  logic                         sink_ready,
  input  logic                         flush,
  output logic                         grant_valid,
  output logic [PORT_W-1:0]            grant_port,
  output logic [NUM_PORTS-1:0]         grant_onehot,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic                         full,
  output logic                         empty
);

  localparam int          CNT_W = $clog2(DEPTH + 1);
  localparam int          PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned NP    = NUM_PORTS;

  logic [PORT_W-1:0]    fifo_mem [DEPTH];
  logic [PTR_W-1:0]     head, tail, head_nxt, tail_nxt;
  logic [NUM_PORTS-1:0] queued, queued_nxt, avail, cand_onehot;
  logic [PORT_W-1:0]    rr, rr_nxt, cand;
  logic                 cand_valid;
  logic                 can_grant, do_pop, do_push, do_bypass, accept;
  logic [CNT_W-1:0]     count_nxt;
  logic                 grant_valid_nxt;
  logic [PORT_W-1:0]    grant_port_nxt;
  logic [NUM_PORTS-1:0] grant_onehot_nxt;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  // Candidate: one unqueued requester, lowest index or rotating from rr+1.
  always_comb begin
    int unsigned idx;
    idx        = 0;
    avail      = req & ~queued;
    cand       = '0;
    cand_valid = 1'b0;
    for (int unsigned k = 0; k < NP; k++) begin
      idx = TIE_RR ? ((32'(rr) + 32'd1 + k) % NP) : k;
      if (!cand_valid && avail[idx]) begin
        cand_valid = 1'b1;
        cand       = PORT_W'(idx);
      end
    end
  end

  // Flush outranks everything; a full queue only blocks pushes while no pop frees a slot.
  always_comb begin
    can_grant   = sink_ready & ~grant_valid;
    do_pop      = ~flush & can_grant & ~empty;
    do_bypass   = ~flush & can_grant & empty & cand_valid;
    do_push     = ~flush & cand_valid & (do_pop | (~can_grant & ~full));
    accept      = do_push | do_bypass;
    cand_onehot = accept ? (NUM_PORTS'(1) << cand) : '0;

    count_nxt = count;
    if (flush)                    count_nxt = '0;
    else if (do_push && !do_pop)  count_nxt = count + CNT_W'(1);
    else if (do_pop && !do_push)  count_nxt = count - CNT_W'(1);

    head_nxt   = flush ? '0 : (do_pop  ? ptr_inc(head) : head);
    tail_nxt   = flush ? '0 : (do_push ? ptr_inc(tail) : tail);
    queued_nxt = flush ? '0 : ((queued & req) | cand_onehot);
    rr_nxt     = flush ? '0 : (accept ? cand : rr);

    grant_valid_nxt = do_pop | do_bypass;
    grant_port_nxt  = '0;
    if (do_pop)         grant_port_nxt = fifo_mem[head];
    else if (do_bypass) grant_port_nxt = cand;
    grant_onehot_nxt = grant_valid_nxt ? (NUM_PORTS'(1) << grant_port_nxt) : '0;
  end

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      head         <= '0;
      tail         <= '0;
      queued       <= '0;
      rr           <= '0;
      count        <= '0;
      full         <= 1'b0;
      empty        <= 1'b1;
      grant_valid  <= 1'b0;
      grant_port   <= '0;
      grant_onehot <= '0;
    end else begin
      head         <= head_nxt;
      tail         <= tail_nxt;
      queued       <= queued_nxt;
      rr           <= rr_nxt;
      count        <= count_nxt;
      full         <= (count_nxt == CNT_W'(DEPTH));
      empty        <= (count_nxt == '0);
      grant_valid  <= grant_valid_nxt;
      grant_port   <= grant_port_nxt;
      grant_onehot <= grant_onehot_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) fifo_mem[tail] <= cand;
  end

endmodule

// File: tb/tb_req_order_arbiter.sv
// Directed bench for req_order_arbiter: three instances (default, DEPTH=2,
// TIE_RR=1) with a master model that drops each request on its grant.
module tb_req_order_arbiter;

  logic       clk;
  logic       rst_b;
  logic [3:0] req        [3];
  logic       sink_ready [3];
  logic       flush      [3];
  logic       gv         [3];
  logic [1:0] gp         [3];
  logic [3:0] go         [3];
  logic       full_o     [3];
  logic       empty_o    [3];
  logic [2:0] cnt0, cnt2;
  logic [1:0] cnt1;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  int log_port[$];
  int log_cyc[$];

  req_order_arbiter #(.NUM_PORTS(4), .DEPTH(4), .TIE_RR(1'b0)) dut (
    .clk(clk), .rst_b(rst_b), .req(req[0]), .sink_ready(sink_ready[0]), .flush(flush[0]),
    .grant_valid(gv[0]), .grant_port(gp[0]), .grant_onehot(go[0]),
    .count(cnt0), .full(full_o[0]), .empty(empty_o[0]));

  req_order_arbiter #(.NUM_PORTS(4), .DEPTH(2), .TIE_RR(1'b0)) dut_d2 (
    .clk(clk), .rst_b(rst_b), .req(req[1]), .sink_ready(sink_ready[1]), .flush(flush[1]),
    .grant_valid(gv[1]), .grant_port(gp[1]), .grant_onehot(go[1]),
    .count(cnt1), .full(full_o[1]), .empty(empty_o[1]));

  req_order_arbiter #(.NUM_PORTS(4), .DEPTH(4), .TIE_RR(1'b1)) dut_rr (
    .clk(clk), .rst_b(rst_b), .req(req[2]), .sink_ready(sink_ready[2]), .flush(flush[2]),
    .grant_valid(gv[2]), .grant_port(gp[2]), .grant_onehot(go[2]),
    .count(cnt2), .full(full_o[2]), .empty(empty_o[2]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic int cnt_of(input int sel);
    case (sel)
      0:       return int'(cnt0);
      1:       return int'(cnt1);
      default: return int'(cnt2);
    endcase
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  // Master model: log each grant, drop that request; optionally re-raise it a cycle later.
  task automatic run(input int sel, input int ncyc, input bit rearm_en);
    logic [3:0] rearm;
    rearm = '0;
    for (int n = 0; n < ncyc; n++) begin
      step();
      req[sel] = req[sel] | rearm;
      rearm    = '0;
      if (gv[sel]) begin
        log_port.push_back(int'(gp[sel]));
        log_cyc.push_back(cyc);
        req[sel][gp[sel]] = 1'b0;
        if (rearm_en) rearm[gp[sel]] = 1'b1;
      end
    end
  endtask

  task automatic test_reset();
    for (int s = 0; s < 3; s++) begin
      checks++;
      if (gv[s] !== 1'b0 || gp[s] !== 2'd0 || go[s] !== 4'd0 || cnt_of(s) != 0 ||
          full_o[s] !== 1'b0 || empty_o[s] !== 1'b1) begin
        errors++;
        $display("FAIL reset[%0d]: got gv=%b gp=%0d go=%b cnt=%0d full=%b empty=%b expected 0 0 0000 0 0 1",
                 s, gv[s], gp[s], go[s], cnt_of(s), full_o[s], empty_o[s]);
      end
    end
  endtask

  task automatic test_bypass();
    sink_ready[0] = 1'b1;
    req[0]        = 4'b0001;
    step();
    checks++;
    if (gv[0] !== 1'b1 || gp[0] !== 2'd0 || go[0] !== 4'b0001 || cnt_of(0) != 0) begin
      errors++;
      $display("FAIL bypass_grant: got gv=%b gp=%0d go=%b cnt=%0d expected 1 0 0001 0",
               gv[0], gp[0], go[0], cnt_of(0));
    end
    req[0] = 4'b0000;
    step();
    checks++;
    if (gv[0] !== 1'b0 || go[0] !== 4'b0000) begin
      errors++;
      $display("FAIL bypass_pulse: got gv=%b go=%b expected 0 0000", gv[0], go[0]);
    end
    step();
  endtask

  task automatic test_queue_fill();
    int exp_q[$];
    exp_q = '{0, 1, 3};
    sink_ready[0] = 1'b0;
    req[0]        = 4'b1011;
    for (int i = 1; i <= 3; i++) begin
      step();
      checks++;
      if (cnt_of(0) != i || gv[0] !== 1'b0) begin
        errors++;
        $display("FAIL fill_count[%0d]: got cnt=%0d gv=%b expected %0d 0", i, cnt_of(0), gv[0], i);
      end
    end
    log_port.delete();
    log_cyc.delete();
    sink_ready[0] = 1'b1;
    run(0, 12, 1'b0);
    checks++;
    if (log_port.size() != 3) begin
      errors++;
      $display("FAIL fill_grants: got %0d grants expected 3", log_port.size());
    end
    for (int i = 0; i < exp_q.size(); i++) begin
      int got;
      got = (i < log_port.size()) ? log_port[i] : -1;
      checks++;
      if (got != exp_q[i]) begin
        errors++;
        $display("FAIL fill_order[%0d]: got %0d expected %0d", i, got, exp_q[i]);
      end
    end
    for (int i = 1; i < log_cyc.size(); i++) begin
      checks++;
      if (log_cyc[i] - log_cyc[i-1] < 2) begin
        errors++;
        $display("FAIL fill_spacing[%0d]: got %0d cycles expected >=2", i, log_cyc[i] - log_cyc[i-1]);
      end
    end
    checks++;
    if (cnt_of(0) != 0 || empty_o[0] !== 1'b1) begin
      errors++;
      $display("FAIL fill_drain: got cnt=%0d empty=%b expected 0 1", cnt_of(0), empty_o[0]);
    end
  endtask

  task automatic test_arrival_order();
    sink_ready[0] = 1'b0;
    req[0]        = 4'b1000;
    step();
    step();
    req[0][0] = 1'b1;
    step();
    checks++;
    if (cnt_of(0) != 2) begin
      errors++;
      $display("FAIL arrival_count: got %0d expected 2", cnt_of(0));
    end
    log_port.delete();
    log_cyc.delete();
    sink_ready[0] = 1'b1;
    run(0, 8, 1'b0);
    checks++;
    if (log_port.size() != 2 || log_port[0] != 3 || log_port[1] != 0) begin
      errors++;
      $display("FAIL arrival_order: got %p expected '{3, 0}", log_port);
    end
  endtask

  task automatic test_full();
    sink_ready[1] = 1'b0;
    req[1]        = 4'b1111;
    repeat (3) step();
    checks++;
    if (cnt_of(1) != 2 || full_o[1] !== 1'b1 || empty_o[1] !== 1'b0) begin
      errors++;
      $display("FAIL full_state: got cnt=%0d full=%b empty=%b expected 2 1 0",
               cnt_of(1), full_o[1], empty_o[1]);
    end
    log_port.delete();
    log_cyc.delete();
    sink_ready[1] = 1'b1;
    run(1, 20, 1'b0);
    checks++;
    if (log_port.size() != 4) begin
      errors++;
      $display("FAIL full_grants: got %0d grants expected 4", log_port.size());
    end
    for (int i = 0; i < 4; i++) begin
      int got;
      got = (i < log_port.size()) ? log_port[i] : -1;
      checks++;
      if (got != i) begin
        errors++;
        $display("FAIL full_order[%0d]: got %0d expected %0d", i, got, i);
      end
    end
    checks++;
    if (cnt_of(1) != 0 || full_o[1] !== 1'b0 || empty_o[1] !== 1'b1) begin
      errors++;
      $display("FAIL full_drain: got cnt=%0d full=%b empty=%b expected 0 0 1",
               cnt_of(1), full_o[1], empty_o[1]);
    end
  endtask

  task automatic test_rotating();
    int exp_q[$];
    exp_q = '{0, 1, 2, 3, 0, 1};
    // Prime the rotation pointer on port 3 so the search starts at port 0.
    sink_ready[2] = 1'b1;
    req[2]        = 4'b1000;
    log_port.delete();
    run(2, 4, 1'b0);
    checks++;
    if (log_port.size() != 1 || log_port[0] != 3) begin
      errors++;
      $display("FAIL rr_prime: got %p expected '{3}", log_port);
    end
    log_port.delete();
    log_cyc.delete();
    req[2] = 4'b1111;
    run(2, 20, 1'b1);
    for (int i = 0; i < exp_q.size(); i++) begin
      int got;
      got = (i < log_port.size()) ? log_port[i] : -1;
      checks++;
      if (got != exp_q[i]) begin
        errors++;
        $display("FAIL rr_order[%0d]: got %0d expected %0d", i, got, exp_q[i]);
      end
    end
  endtask

  task automatic test_lowest_first();
    sink_ready[0] = 1'b1;
    req[0]        = 4'b1111;
    log_port.delete();
    log_cyc.delete();
    run(0, 12, 1'b0);
    checks++;
    if (log_port.size() != 4) begin
      errors++;
      $display("FAIL low_grants: got %0d grants expected 4", log_port.size());
    end
    for (int i = 0; i < 4; i++) begin
      int got;
      got = (i < log_port.size()) ? log_port[i] : -1;
      checks++;
      if (got != i) begin
        errors++;
        $display("FAIL low_order[%0d]: got %0d expected %0d", i, got, i);
      end
    end
  endtask

  task automatic test_flush_reset();
    sink_ready[0] = 1'b0;
    req[0]        = 4'b1011;
    repeat (3) step();
    checks++;
    if (cnt_of(0) != 3) begin
      errors++;
      $display("FAIL flush_pre: got cnt=%0d expected 3", cnt_of(0));
    end
    flush[0]      = 1'b1;
    sink_ready[0] = 1'b1;
    step();
    flush[0]      = 1'b0;
    sink_ready[0] = 1'b0;
    checks++;
    if (cnt_of(0) != 0 || gv[0] !== 1'b0 || empty_o[0] !== 1'b1) begin
      errors++;
      $display("FAIL flush_clear: got cnt=%0d gv=%b empty=%b expected 0 0 1",
               cnt_of(0), gv[0], empty_o[0]);
    end
    step();
    checks++;
    if (cnt_of(0) != 1) begin
      errors++;
      $display("FAIL flush_requeue1: got cnt=%0d expected 1", cnt_of(0));
    end
    step();
    step();
    checks++;
    if (cnt_of(0) != 3) begin
      errors++;
      $display("FAIL flush_requeue3: got cnt=%0d expected 3", cnt_of(0));
    end
    sink_ready[0] = 1'b1;
    step();
    checks++;
    if (gv[0] !== 1'b1 || gp[0] !== 2'd0 || go[0] !== 4'b0001) begin
      errors++;
      $display("FAIL requeue_grant: got gv=%b gp=%0d go=%b expected 1 0 0001", gv[0], gp[0], go[0]);
    end
    req[0] = 4'b1010;
    #2;
    rst_b = 1'b0;
    #1;
    checks++;
    if (gv[0] !== 1'b0 || gp[0] !== 2'd0 || go[0] !== 4'd0 || cnt_of(0) != 0 ||
        full_o[0] !== 1'b0 || empty_o[0] !== 1'b1) begin
      errors++;
      $display("FAIL async_reset: got gv=%b gp=%0d go=%b cnt=%0d full=%b empty=%b expected 0 0 0000 0 0 1",
               gv[0], gp[0], go[0], cnt_of(0), full_o[0], empty_o[0]);
    end
    rst_b         = 1'b1;
    sink_ready[0] = 1'b0;
    step();
    step();
    checks++;
    if (cnt_of(0) != 2 || gv[0] !== 1'b0) begin
      errors++;
      $display("FAIL reset_requeue: got cnt=%0d gv=%b expected 2 0", cnt_of(0), gv[0]);
    end
  endtask

  initial begin
    rst_b = 1'b0;
    for (int s = 0; s < 3; s++) begin
      req[s]        = '0;
      sink_ready[s] = 1'b0;
      flush[s]      = 1'b0;
    end
    repeat (2) @(posedge clk);
    #1;
    test_reset();
    rst_b = 1'b1;
    step();
    test_reset();
    test_bypass();
    test_queue_fill();
    test_arrival_order();
    test_full();
    test_rotating();
    test_lowest_first();
    test_flush_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
